// File: rtl/arf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arf_pkg
// Brief    : Shared constants and handshake state type for the ARF FIFO
//            responder.
// Revision : 1.0 - initial release
// ============================================================================
package arf_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 32;
    localparam int c_COUNT_WIDTH        = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } arf_state_e;

endpackage
`default_nettype wire

// File: rtl/arf_fifo_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : arf_fifo_responder_if
// Brief    : Pull-style req/ack channels on both sides of the FIFO responder.
// Revision : 1.0 - initial release
// ============================================================================
interface arf_fifo_responder_if
    import arf_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH
);
    logic                  req_l;
    logic                  ack_l;
    logic [DATA_WIDTH-1:0] din;
    logic                  req_r;
    logic                  ack_r;
    logic [DATA_WIDTH-1:0] dout;

    // master: the environment around the block; slave: the block itself
    modport master (
        input  req_l, ack_r, dout,
        output ack_l, din, req_r
    );

    modport slave (
        output req_l, ack_r, dout,
        input  ack_l, din, req_r
    );
endinterface
`default_nettype wire

// File: rtl/arf_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : arf_fifo_mem
// Brief    : Circular FIFO storage with head/tail pointers and occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module arf_fifo_mem
    import arf_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_push,
    input  wire logic [DATA_WIDTH-1:0]      i_wdata,
    input  wire logic                       i_pop,
    output logic      [DATA_WIDTH-1:0]      o_rdata,
    output logic      [$clog2(DEPTH):0]     o_level,
    output logic      [$clog2(DEPTH):0]     o_level_next,
    output logic                            o_empty
);
    localparam int                  c_PW   = $clog2(DEPTH);
    localparam int                  c_LW   = c_PW + 1;
    localparam logic [c_LW-1:0]     c_FULL = c_LW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]       r_head;
    logic [c_PW-1:0]       r_tail;
    logic [c_LW-1:0]       r_level;
    logic [c_LW-1:0]       w_level_next;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    // A push while full is an upstream protocol error; the word is dropped.
    assign w_push_ok = i_push && (r_level != c_FULL);
    assign w_pop_ok  = i_pop  && (r_level != '0);

    always_comb begin
        w_level_next = r_level;
        if (w_push_ok && !w_pop_ok) begin
            w_level_next = r_level + c_LW'(1);
        end else if (!w_push_ok && w_pop_ok) begin
            w_level_next = r_level - c_LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
        end else begin
            r_level <= w_level_next;
            if (w_push_ok) begin
                r_tail <= r_tail + c_PW'(1);
            end
            if (w_pop_ok) begin
                r_head <= r_head + c_PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_tail] <= i_wdata;
        end
    end

    assign o_rdata      = r_mem[r_head];
    assign o_level      = r_level;
    assign o_level_next = w_level_next;
    assign o_empty      = (r_level == '0);

endmodule
`default_nettype wire

// File: rtl/arf_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module   : arf_fifo_responder
// Brief    : FIFO bridging an upstream pull responder to a downstream puller.
//            Define ARF_FIFO_COUNT_EN to enable the delivered-word counter.
// Revision : 1.0 - initial release
// ============================================================================
module arf_fifo_responder
    import arf_pkg::*;
#(
    parameter int DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    arf_fifo_responder_if.slave             bus,
    output logic      [$clog2(DEPTH):0]     level,
    output logic      [c_COUNT_WIDTH-1:0]   count
);
    localparam int              c_LW   = $clog2(DEPTH) + 1;
    localparam logic [c_LW-1:0] c_FULL = c_LW'(DEPTH);

    arf_state_e            r_state;
    arf_state_e            w_state_next;
    logic                  w_pop;
    logic                  w_empty;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [c_LW-1:0]       w_level_next;
    logic                  r_req_l;
    logic [DATA_WIDTH-1:0] r_dout;

    arf_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk          (clk),
        .rst          (rst),
        .i_push       (bus.ack_l),
        .i_wdata      (bus.din),
        .i_pop        (w_pop),
        .o_rdata      (w_head_data),
        .o_level      (level),
        .o_level_next (w_level_next),
        .o_empty      (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.req_r && !w_empty) w_state_next = ST_ACK;
            ST_ACK:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Emptiness is the pre-edge occupancy, so a fresh push cannot bypass.
    always_comb begin
        w_pop     = (r_state == ST_IDLE) && bus.req_r && !w_empty;
        bus.ack_r = (r_state == ST_ACK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req_l <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_req_l <= (w_level_next != c_FULL);
            if (w_pop) begin
                r_dout <= w_head_data;
            end
        end
    end

    assign bus.req_l = r_req_l;
    assign bus.dout  = r_dout;

`ifdef ARF_FIFO_COUNT_EN
    logic [c_COUNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (w_pop) begin
            r_count <= r_count + c_COUNT_WIDTH'(1);
        end
    end

    assign count = r_count;
`else
    assign count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_arf_fifo_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_arf_fifo_responder
// Brief    : Self-checking bench for arf_fifo_responder (DEPTH=4, 32-bit data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arf_fifo_responder;

    logic        clk;
    logic        rst;
    logic [2:0]  level;
    logic [31:0] count;
    int          checks;
    int          failures;

    arf_fifo_responder_if #(.DATA_WIDTH(32)) bus ();

    arf_fifo_responder #(
        .DATA_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .level (level),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ack_l;
        logic [31:0] din;
        logic        req_r;
        logic        e_ack_r;
        logic [31:0] e_dout;
        logic [2:0]  e_level;
        logic        e_req_l;
        int          e_pops;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef ARF_FIFO_COUNT_EN
        return 32'(n);
`else
        return (n == -1) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.ack_l = 1'b0;
        bus.req_r = 1'b0;
        bus.din   = '0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Producer acks at most every other cycle while req_l is high; consumer
    // pulls continuously or with random drops. Words are 0,1,2,...
    task automatic run_stream(input int nwords, input bit rnd, input int budget);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit acked_prev = 1'b0;
        while (got < nwords && cyc < budget) begin
            if (bus.ack_r) begin
                chk("stream_dout", bus.dout, 64'(got));
                got++;
            end
            chk("stream_level_bound", (level <= 3'd4), 1'b1);
            if (!acked_prev && bus.req_l && sent < nwords) begin
                bus.ack_l  = 1'b1;
                bus.din    = 32'(sent);
                sent++;
                acked_prev = 1'b1;
            end else begin
                bus.ack_l  = 1'b0;
                acked_prev = 1'b0;
            end
            bus.req_r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            cyc++;
        end
        bus.ack_l = 1'b0;
        bus.req_r = 1'b0;
        chk("stream_words_delivered", 64'(got), 64'(nwords));
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //                ack din       rr  ackr dout      lvl  reql pops
        tbl[0]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 3'd0, 1'b1, 0};
        tbl[1]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 32'h00, 3'd1, 1'b1, 0};
        tbl[2]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'hA1, 3'd0, 1'b1, 1};
        tbl[3]  = '{1'b1, 32'hB2, 1'b1, 1'b0, 32'hA1, 3'd1, 1'b1, 1};
        tbl[4]  = '{1'b1, 32'hC3, 1'b1, 1'b1, 32'hB2, 3'd1, 1'b1, 2};
        tbl[5]  = '{1'b1, 32'hD4, 1'b0, 1'b0, 32'hB2, 3'd2, 1'b1, 2};
        tbl[6]  = '{1'b1, 32'hE5, 1'b0, 1'b0, 32'hB2, 3'd3, 1'b1, 2};
        tbl[7]  = '{1'b1, 32'hF6, 1'b0, 1'b0, 32'hB2, 3'd4, 1'b0, 2};
        tbl[8]  = '{1'b1, 32'h77, 1'b0, 1'b0, 32'hB2, 3'd4, 1'b0, 2};
        tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 32'hC3, 3'd3, 1'b1, 3};
        tbl[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'hC3, 3'd3, 1'b1, 3};
        tbl[11] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'hD4, 3'd2, 1'b1, 4};
        tbl[12] = '{1'b1, 32'h88, 1'b0, 1'b0, 32'hD4, 3'd3, 1'b1, 4};
        tbl[13] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'hE5, 3'd2, 1'b1, 5};
        tbl[14] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'hE5, 3'd2, 1'b1, 5};
        tbl[15] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'hF6, 3'd1, 1'b1, 6};
        tbl[16] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'hF6, 3'd1, 1'b1, 6};
        tbl[17] = '{1'b0, 32'h00, 1'b1, 1'b1, 32'h88, 3'd0, 1'b1, 7};
        tbl[18] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h88, 3'd0, 1'b1, 7};
        tbl[19] = '{1'b0, 32'h00, 1'b1, 1'b0, 32'h88, 3'd0, 1'b1, 7};

        bus.ack_l = 1'b0;
        bus.req_r = 1'b0;
        bus.din   = '0;
        rst       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_req_l", bus.req_l, 1'b0);
        chk("reset_ack_r", bus.ack_r, 1'b0);
        chk("reset_dout",  bus.dout,  32'h0);
        chk("reset_level", level,     3'd0);
        chk("reset_count", count,     32'h0);
        rst = 1'b1;

        // Directed table: each row is one clock edge.
        for (int i = 0; i < 20; i++) begin
            bus.ack_l = tbl[i].ack_l;
            bus.din   = tbl[i].din;
            bus.req_r = tbl[i].req_r;
            cycle();
            chk($sformatf("vec%0d_ack_r", i), bus.ack_r, tbl[i].e_ack_r);
            chk($sformatf("vec%0d_dout", i),  bus.dout,  tbl[i].e_dout);
            chk($sformatf("vec%0d_level", i), level,     tbl[i].e_level);
            chk($sformatf("vec%0d_req_l", i), bus.req_l, tbl[i].e_req_l);
            chk($sformatf("vec%0d_count", i), count,     exp_cnt(tbl[i].e_pops));
        end

        // Single push, consumer already pulling: ack_r two cycles after ack_l.
        do_reset();
        cycle();
        bus.ack_l = 1'b1; bus.din = 32'h5; bus.req_r = 1'b1;
        cycle();
        bus.ack_l = 1'b0;
        chk("single_ack_r_c1", bus.ack_r, 1'b0);
        chk("single_level_c1", level, 3'd1);
        cycle();
        chk("single_ack_r_c2", bus.ack_r, 1'b1);
        chk("single_dout",     bus.dout,  32'h5);
        chk("single_level_c2", level, 3'd0);
        bus.req_r = 1'b0;

        // Fill with a rate-limited producer, then drain on alternate cycles.
        do_reset();
        cycle();
        begin
            int  sent = 0;
            bit  prev = 1'b0;
            for (int k = 0; k < 12; k++) begin
                if (!prev && bus.req_l) begin
                    bus.ack_l = 1'b1; bus.din = 32'(sent); sent++; prev = 1'b1;
                end else begin
                    bus.ack_l = 1'b0; prev = 1'b0;
                end
                cycle();
            end
            bus.ack_l = 1'b0;
            chk("fill_sent",  64'(sent), 64'd4);
            chk("fill_level", level,     3'd4);
            chk("fill_req_l", bus.req_l, 1'b0);
        end
        bus.req_r = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk($sformatf("drain%0d_ack_r", k), bus.ack_r, (k % 2 == 0));
            if (k % 2 == 0) chk($sformatf("drain%0d_dout", k), bus.dout, 64'(k / 2));
        end
        bus.req_r = 1'b0;
        chk("drain_level", level, 3'd0);

        // Push and pop on the same edge at level 2.
        do_reset();
        cycle();
        bus.ack_l = 1'b1; bus.din = 32'h11; cycle();
        bus.ack_l = 1'b0;                   cycle();
        bus.ack_l = 1'b1; bus.din = 32'h22; cycle();
        chk("pp_level_pre", level, 3'd2);
        bus.ack_l = 1'b1; bus.din = 32'h33; bus.req_r = 1'b1; cycle();
        bus.ack_l = 1'b0;
        chk("pp_level",  level,     3'd2);
        chk("pp_ack_r",  bus.ack_r, 1'b1);
        chk("pp_dout",   bus.dout,  32'h11);
        cycle();
        cycle();
        chk("pp_dout_next", bus.dout, 32'h22);
        chk("pp_level_next", level, 3'd1);
        bus.req_r = 1'b0;

        // Asynchronous reset while acking with three words left.
        do_reset();
        cycle();
        for (int k = 0; k < 4; k++) begin
            bus.ack_l = 1'b1; bus.din = 32'h40 + 32'(k); cycle();
        end
        bus.ack_l = 1'b0; bus.req_r = 1'b1; cycle();
        chk("mid_ack_r_pre", bus.ack_r, 1'b1);
        chk("mid_level_pre", level,     3'd3);
        rst = 1'b0; bus.ack_l = 1'b1; bus.din = 32'h55; bus.req_r = 1'b0;
        #1;
        chk("mid_rst_ack_r", bus.ack_r, 1'b0);
        chk("mid_rst_dout",  bus.dout,  32'h0);
        chk("mid_rst_level", level,     3'd0);
        chk("mid_rst_count", count,     32'h0);
        @(negedge clk);
        cycle();
        chk("mid_rst_level_held", level, 3'd0);
        bus.ack_l = 1'b0;
        rst = 1'b1;
        cycle();
        chk("post_rst_req_l", bus.req_l, 1'b1);
        bus.ack_l = 1'b1; bus.din = 32'h99; cycle();
        bus.ack_l = 1'b0; bus.req_r = 1'b1; cycle();
        chk("post_rst_ack_r", bus.ack_r, 1'b1);
        chk("post_rst_dout",  bus.dout,  32'h99);
        chk("post_rst_count", count,     exp_cnt(1));
        bus.req_r = 1'b0;

        // Continuous streaming, then random consumer drops.
        do_reset();
        run_stream(5000, 1'b0, 12000);
        chk("stream5000_count", count, exp_cnt(5000));
        do_reset();
        run_stream(1000, 1'b1, 10000);
        chk("stream1000_count", count, exp_cnt(1000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arf_fifo_responder.md
ARF_FIFO_RESPONDER -- requirements
Module: arf_fifo_responder

Interface
REQ-001 Parameter data_width, default 32, width of din/dout.
REQ-002 Parameter depth, default 4, FIFO entries; power of two, >= 2.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_l  output  1  pull request to upstream responder (initiator side).
REQ-007 ack_l  input  1  upstream one-cycle ack; din valid in same cycle.
REQ-008 din  input  data_width  upstream data.
REQ-009 req_r  input  1  downstream pull request (responder side).
REQ-010 ack_r  output  1  one-cycle ack to downstream; dout valid while high.
REQ-011 dout  output  data_width  delivered word, registered.
REQ-012 level  output  $clog2(depth)+1  current occupancy.
REQ-013 count  output  32  words delivered downstream (see Configuration).

Function
REQ-014 Push: on any edge with ack_l=1, din written at tail, tail advances, regardless of req_l value that cycle.
REQ-015 req_l registered: set to 1 iff occupancy after the edge < depth, else 0.
REQ-016 Overflow impossible: upstream issues at most one ack per req_l-high/ack-low sample; ack_l while full is a protocol error, word dropped, occupancy unchanged.
REQ-017 Responder FSM, two states: IDLE, ACK.
REQ-018 IDLE -> ACK when req_r=1 and occupancy>0: ack_r<=1, dout<=head word, head advances.
REQ-019 ACK -> IDLE unconditionally next edge: ack_r<=0, dout holds last value.
REQ-020 IDLE stays IDLE when req_r=0 or FIFO empty; ack_r stays 0.
REQ-021 Max rate one word per two cycles on each side, matching the req/ack protocol.
REQ-022 Simultaneous push and pop on one edge: occupancy unchanged, both pointers advance.
REQ-023 Push into empty FIFO: word eligible for pop at earliest on the following edge (no same-edge bypass).
REQ-024 Pointers wrap modulo depth; level 0..depth inclusive.
REQ-025 Order preserved: dout sequence equals accepted din sequence.

Reset
REQ-026 rst low asynchronously: req_l=0, ack_r=0, dout=0, level=0, count=0, pointers=0, FSM=IDLE.
REQ-027 Reset mid-transfer discards all stored words; an ack_l arriving during reset is ignored.
REQ-028 First edge after release: req_l<=1 (FIFO empty).

Configuration
REQ-029 Macro ARF_FIFO_COUNT_EN defined: count increments (mod 2^32) on each IDLE->ACK transition.
REQ-030 Macro undefined: count port present, tied to 0, counter logic absent.

Structure
REQ-031 Package arf_pkg: default data width, handshake FSM state enum (IDLE, ACK), count width constant 32.
REQ-032 Sub-module arf_fifo_mem: storage array, head/tail pointers, level; no handshake logic.

Verification
REQ-033 Reset then single push din=0x5 via ack_l, req_r held 1 -> ack_r pulse 2 cycles after ack_l, dout=0x5, level back to 0.
REQ-034 depth=4, req_r=0, upstream producer acks 0..3 -> level=4, req_l=0; no fifth ack; req_r=1 -> dout 0,1,2,3 on alternate cycles.
REQ-035 Both sides running continuously with producer model, 5000 words -> dout strictly incrementing, count=5000 with ARF_FIFO_COUNT_EN, 0 without.
REQ-036 Level=2, push and pop on same edge -> level stays 2, popped word is oldest.
REQ-037 rst asserted while ack_r=1 and level=3 -> ack_r, dout, level, count immediately 0; after release first word delivered is first post-reset push.
REQ-038 Random req_r drops (50%) on consumer side -> no lost, duplicated or reordered words over 1000 transfers; level never exceeds depth.
